// File: rtl/i2s_serial_transmitter.sv
// i2s_serial_transmitter: I2S DAC link driver with a one-frame stereo buffer.
// Define I2S_TX_REPEAT_ON_UNDERRUN_EN to retransmit the last good pair on underrun.
module i2s_serial_transmitter #(
  parameter int audio_width = 16,
  parameter int slot_width = 16,
  parameter int sclk_div = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_is_left,
  input  logic [audio_width-1:0] i_audio,
  output logic                   o_sclk,
  output logic                   o_lrclk,
  output logic                   o_sdata,
  output logic                   o_underrun,
  output logic                   o_sync_error
);
  localparam int fw = 2 * slot_width;
  localparam int kw = $clog2(fw);
  localparam int dw = $clog2(sclk_div + 1);
  logic [dw-1:0] div;
  logic [kw-1:0] k, k_nx;
  logic [fw-1:0] sh, pair, src;
  logic [audio_width-1:0] l_buf, r_buf;
  logic l_full, r_full, exp_left, wrap, fall, load, full, xfer;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [fw-1:0] last;
  assign src = full ? pair : last;
`else
  assign src = full ? pair : '0;
`endif
  assign wrap = div == dw'(sclk_div - 1);
  assign fall = wrap & o_sclk;
  assign k_nx = k == kw'(fw - 1) ? '0 : k + 1'b1;
  assign load = fall && k_nx == '0;
  assign full = l_full & r_full;
  assign xfer = i_valid & i_ready;
  assign i_ready = reset & (exp_left ? !l_full : !r_full);
  // Frame word holds each sample MSB-aligned in its slot, so shifting out the top bit gives the I2S order.
  assign pair = (fw'(l_buf) << (fw - audio_width)) | (fw'(r_buf) << (slot_width - audio_width));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      k <= kw'(fw - 1);
      sh <= '0;
      l_buf <= '0;
      r_buf <= '0;
      l_full <= 1'b0;
      r_full <= 1'b0;
      exp_left <= 1'b1;
      o_sclk <= 1'b1;
      o_lrclk <= 1'b0;
      o_sdata <= 1'b0;
      o_underrun <= 1'b0;
      o_sync_error <= 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last <= '0;
`endif
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      o_underrun <= 1'b0;
      o_sync_error <= xfer && (i_is_left != exp_left);
      if (wrap) o_sclk <= ~o_sclk;
      if (fall) begin
        k <= k_nx;
        o_lrclk <= k_nx >= kw'(slot_width - 1) && k_nx <= kw'(fw - 2);
        o_sdata <= load ? src[fw-1] : sh[fw-1];
        sh <= load ? src << 1 : sh << 1;
        if (load) o_underrun <= !full;
      end
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      if (load && full) last <= pair;
`endif
      if (load && full) begin
        l_full <= 1'b0;
        r_full <= 1'b0;
        exp_left <= 1'b1;
      end else if (xfer && i_is_left == exp_left) begin
        if (exp_left) begin
          l_buf <= i_audio;
          l_full <= 1'b1;
        end else begin
          r_buf <= i_audio;
          r_full <= 1'b1;
        end
        exp_left <= ~exp_left;
      end
    end
  end
endmodule
